// File: rtl/fpu_issue_seq.sv
// Issue sequencer between the integer core and the FPAdder: latches one float command,
// runs the adder until stall falls (or a timeout), and returns the tagged result.
module fpu_issue_seq #(
  parameter logic [31:0] FLT_MAGIC = 32'h4B00_0000,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TAGW      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  input  logic [TAGW-1:0] cmd_tag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic [TAGW-1:0] res_tag,
  output logic            res_err,
  output logic            fpa_run,
  output logic            fpa_u,
  output logic            fpa_v,
  output logic [31:0]     fpa_x,
  output logic [31:0]     fpa_y,
  input  logic            fpa_stall,
  input  logic [31:0]     fpa_z,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
  typedef enum logic [1:0] {OP_FAD, OP_FSB, OP_FLT, OP_FLR} op_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;
  logic [TAGW-1:0] r_tag;
  logic            w_accept;
  logic            w_tmo;
  logic            w_capture;

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_tmo     = (r_cnt == 8'(TIMEOUT - 1));
  assign w_capture = (r_state == S_RUN) & (~fpa_stall | w_tmo);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_capture) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accept only when a held result is absent or leaves on this same edge.
  always_comb begin
    cmd_ready = 1'b0;
    fpa_run   = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = ~res_valid | res_ready;
        busy      = 1'b0;
      end
      S_RUN:   fpa_run = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpa_x     <= '0;
      fpa_y     <= '0;
      fpa_u     <= 1'b0;
      fpa_v     <= 1'b0;
      r_tag     <= '0;
      r_cnt     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        fpa_x <= cmd_a;
        r_tag <= cmd_tag;
        r_cnt <= '0;
        case (op_t'(cmd_op))
          OP_FAD: begin
            fpa_y <= cmd_b;
            fpa_u <= 1'b0;
            fpa_v <= 1'b0;
          end
          OP_FSB: begin
            fpa_y <= {~cmd_b[31], cmd_b[30:0]};
            fpa_u <= 1'b0;
            fpa_v <= 1'b0;
          end
          OP_FLT: begin
            fpa_y <= FLT_MAGIC;
            fpa_u <= 1'b1;
            fpa_v <= 1'b0;
          end
          default: begin
            fpa_y <= FLT_MAGIC;
            fpa_u <= 1'b0;
            fpa_v <= 1'b1;
          end
        endcase
      end
      if (r_state == S_RUN) r_cnt <= r_cnt + 8'd1;
      if (res_valid && res_ready) res_valid <= 1'b0;
      // A capture on the same edge as a consume overrides the clear above.
      if (w_capture) begin
        res_valid <= 1'b1;
        res_tag   <= r_tag;
        if (!fpa_stall) begin
          res_data <= fpa_z;
          res_err  <= 1'b0;
        end else begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
      end
    end
  end

endmodule
